// File: rtl/ram_copy_pkg.sv
`default_nettype none
// ============================================================
// Module : ram_copy_pkg
// Brief  : Shared state encoding and timing constants for ram_copy_dma.
// Rev    : 1.0
// ============================================================
package ram_copy_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    LATCH = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } t_copy_state;

  localparam int CYCLES_PER_WORD_COPY = 3;
  localparam int CYCLES_PER_WORD_FILL = 1;

endpackage
`default_nettype wire

// File: rtl/ram_copy_dma.sv
`default_nettype none
// ============================================================
// Module : ram_copy_dma
// Brief  : Copies in_len words between RAM address ranges over one
//          single-port RAM port; optional fill mode via RAM_COPY_FILL_EN.
// Rev    : 1.0
// ============================================================
module ram_copy_dma
  import ram_copy_pkg::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int WORD_BITS = 8
) (
  input  logic                 in_clk,
  input  logic                 in_rst,
  input  logic                 in_start,
  input  logic [ADDR_BITS-1:0] in_src_addr,
  input  logic [ADDR_BITS-1:0] in_dst_addr,
  input  logic [ADDR_BITS:0]   in_len,
`ifdef RAM_COPY_FILL_EN
  input  logic                 in_fill_mode,
  input  logic [WORD_BITS-1:0] in_fill_value,
`endif
  output logic                 out_busy,
  output logic                 out_done,
  output logic                 out_ram_read_ena,
  output logic                 out_ram_write_ena,
  output logic [ADDR_BITS-1:0] out_ram_addr,
  output logic [WORD_BITS-1:0] out_ram_data,
  input  logic [WORD_BITS-1:0] in_ram_data
);

  t_copy_state          r_state;
  logic [ADDR_BITS-1:0] r_src;
  logic [ADDR_BITS-1:0] r_dst;
  logic [ADDR_BITS:0]   r_len;
  logic [ADDR_BITS:0]   r_cnt;
  logic [WORD_BITS-1:0] r_buf;
  logic [ADDR_BITS-1:0] r_addr;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_rd_ena;
  logic                 r_wr_ena;

  logic [ADDR_BITS:0]   w_cnt_nxt;
  logic                 w_start_fill;
  logic [WORD_BITS-1:0] w_start_word;
  logic                 w_run_fill;
  logic [WORD_BITS-1:0] w_run_word;

`ifdef RAM_COPY_FILL_EN
  logic                 r_fill_mode;
  logic [WORD_BITS-1:0] r_fill_value;

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      r_fill_mode  <= 1'b0;
      r_fill_value <= '0;
    end else if (r_state == IDLE && in_start) begin
      r_fill_mode  <= in_fill_mode;
      r_fill_value <= in_fill_value;
    end
  end

  assign w_start_fill = in_fill_mode;
  assign w_start_word = in_fill_value;
  assign w_run_fill   = r_fill_mode;
  assign w_run_word   = r_fill_value;
`else
  assign w_start_fill = 1'b0;
  assign w_start_word = '0;
  assign w_run_fill   = 1'b0;
  assign w_run_word   = '0;
`endif

  assign w_cnt_nxt = r_cnt + 1'b1;

  // Outputs are registered alongside the state they belong to, so the RAM
  // port sees clean Moore signals with no path from in_ram_data.
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      r_state  <= IDLE;
      r_src    <= '0;
      r_dst    <= '0;
      r_len    <= '0;
      r_cnt    <= '0;
      r_buf    <= '0;
      r_addr   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_rd_ena <= 1'b0;
      r_wr_ena <= 1'b0;
    end else begin
      r_rd_ena <= 1'b0;
      r_wr_ena <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (in_start) begin
            r_src  <= in_src_addr;
            r_dst  <= in_dst_addr;
            r_len  <= in_len;
            r_cnt  <= '0;
            r_busy <= 1'b1;
            if (in_len == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else if (w_start_fill) begin
              r_state  <= WRITE;
              r_wr_ena <= 1'b1;
              r_addr   <= in_dst_addr;
              r_buf    <= w_start_word;
            end else begin
              r_state  <= READ;
              r_rd_ena <= 1'b1;
              r_addr   <= in_src_addr;
            end
          end
        end
        READ: begin
          r_state <= LATCH;
        end
        LATCH: begin
          r_state  <= WRITE;
          r_buf    <= in_ram_data;
          r_wr_ena <= 1'b1;
          r_addr   <= r_dst;
        end
        WRITE: begin
          r_src <= r_src + 1'b1;
          r_dst <= r_dst + 1'b1;
          r_cnt <= w_cnt_nxt;
          if (w_cnt_nxt == r_len) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else if (w_run_fill) begin
            r_state  <= WRITE;
            r_wr_ena <= 1'b1;
            r_addr   <= r_dst + 1'b1;
            r_buf    <= w_run_word;
          end else begin
            r_state  <= READ;
            r_rd_ena <= 1'b1;
            r_addr   <= r_src + 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign out_busy          = r_busy;
  assign out_done          = r_done;
  assign out_ram_read_ena  = r_rd_ena;
  assign out_ram_write_ena = r_wr_ena;
  assign out_ram_addr      = r_addr;
  assign out_ram_data      = r_buf;

endmodule
`default_nettype wire

// File: tb/tb_ram_copy_dma.sv
`default_nettype none
// ============================================================
// Module : tb_ram_copy_dma
// Brief  : Directed bench for ram_copy_dma against a behavioural 1-port RAM.
// Rev    : 1.0
// ============================================================
module tb_ram_copy_dma;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] src;
  logic [7:0] dst;
  logic [8:0] len;
  logic       busy;
  logic       done;
  logic       ram_re;
  logic       ram_we;
  logic [7:0] ram_addr;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata;
`ifdef RAM_COPY_FILL_EN
  logic       fill_mode;
  logic [7:0] fill_value;
`endif

  logic [7:0] mem [0:255];
  logic       bd_we;
  logic [7:0] bd_addr;
  logic [7:0] bd_data;

  int n_vec;
  int n_err;

  ram_copy_dma #(.ADDR_BITS(8), .WORD_BITS(8)) dut (
    .in_clk            (clk),
    .in_rst            (rst_n),
    .in_start          (start),
    .in_src_addr       (src),
    .in_dst_addr       (dst),
    .in_len            (len),
`ifdef RAM_COPY_FILL_EN
    .in_fill_mode      (fill_mode),
    .in_fill_value     (fill_value),
`endif
    .out_busy          (busy),
    .out_done          (done),
    .out_ram_read_ena  (ram_re),
    .out_ram_write_ena (ram_we),
    .out_ram_addr      (ram_addr),
    .out_ram_data      (ram_wdata),
    .in_ram_data       (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Responder RAM: synchronous, one-cycle read latency, plus a bench backdoor.
  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_re) ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    bd_addr = a;
    bd_data = d;
    bd_we   = 1'b1;
    @(negedge clk);
    bd_we   = 1'b0;
  endtask

  // Starts a transfer and watches it until done; optionally injects a second
  // start pulse at cycle inj_cyc. lat = cycles from start cycle to done (-1 on timeout).
  task automatic run(input logic [7:0] s, input logic [7:0] d, input logic [8:0] l,
                     input int inj_cyc,
                     output int lat, output int busy_cyc, output int rd_cnt,
                     output int wr_cnt, output int both_cnt);
    int cyc;
    lat = -1; busy_cyc = 0; rd_cnt = 0; wr_cnt = 0; both_cnt = 0;
    @(negedge clk);
    src = s; dst = d; len = l; start = 1'b1;
    for (cyc = 1; cyc <= 2000; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy && !done) busy_cyc++;
      if (ram_re) rd_cnt++;
      if (ram_we) wr_cnt++;
      if (ram_re && ram_we) both_cnt++;
      if (done) begin
        lat = cyc;
        break;
      end
      if (cyc == inj_cyc) begin
        src = 8'h12; dst = 8'h60; len = 9'd1; start = 1'b1;
      end
    end
    start = 1'b0;
  endtask

  int lat, bc, rc, wc, bth;
  int saw_done;

  initial begin
    n_vec = 0; n_err = 0;
    rst_n = 1'b0; start = 1'b0; src = '0; dst = '0; len = '0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
`ifdef RAM_COPY_FILL_EN
    fill_mode = 1'b0; fill_value = '0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_rd",   {31'd0, ram_re}, 32'd0);
    chk("rst_wr",   {31'd0, ram_we}, 32'd0);
    chk("rst_addr", {24'd0, ram_addr}, 32'd0);
    chk("rst_data", {24'd0, ram_wdata}, 32'd0);
    rst_n = 1'b1;

    // Basic copy of four words
    for (int i = 0; i < 4; i++) begin
      poke(8'h10 + 8'(i), 8'hA0 + 8'(i));
      poke(8'h40 + 8'(i), 8'h00);
    end
    run(8'h10, 8'h40, 9'd4, 0, lat, bc, rc, wc, bth);
    chk("cp4_lat",  lat, 32'd13);
    chk("cp4_busy", bc, 32'd12);
    chk("cp4_rd",   rc, 32'd4);
    chk("cp4_wr",   wc, 32'd4);
    chk("cp4_both", bth, 32'd0);
    for (int i = 0; i < 4; i++)
      chk("cp4_mem", {24'd0, mem[8'h40 + 8'(i)]}, {24'd0, 8'hA0 + 8'(i)});
    @(negedge clk);
    chk("cp4_idle", {31'd0, busy}, 32'd0);

    // Zero length
    poke(8'h80, 8'h77);
    run(8'h00, 8'h80, 9'd0, 0, lat, bc, rc, wc, bth);
    chk("len0_lat", lat, 32'd1);
    chk("len0_rd",  rc, 32'd0);
    chk("len0_wr",  wc, 32'd0);
    chk("len0_mem", {24'd0, mem[8'h80]}, 32'h77);

    // Source wraps past the top of memory
    poke(8'hFE, 8'h11);
    poke(8'hFF, 8'h22);
    poke(8'h00, 8'h33);
    run(8'hFE, 8'h20, 9'd3, 0, lat, bc, rc, wc, bth);
    chk("wrap_lat", lat, 32'd10);
    chk("wrap_m0", {24'd0, mem[8'h20]}, 32'h11);
    chk("wrap_m1", {24'd0, mem[8'h21]}, 32'h22);
    chk("wrap_m2", {24'd0, mem[8'h22]}, 32'h33);

    // Second start while busy must be ignored
    poke(8'h60, 8'hEE);
    run(8'h10, 8'h50, 9'd4, 5, lat, bc, rc, wc, bth);
    chk("ign_lat", lat, 32'd13);
    chk("ign_wr",  wc, 32'd4);
    chk("ign_m0",  {24'd0, mem[8'h50]}, 32'hA0);
    chk("ign_m3",  {24'd0, mem[8'h53]}, 32'hA3);
    chk("ign_m60", {24'd0, mem[8'h60]}, 32'hEE);
    @(negedge clk);
    chk("ign_idle0", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("ign_idle1", {31'd0, busy}, 32'd0);

    // Asynchronous reset after the second WRITE
    for (int i = 0; i < 4; i++) poke(8'h70 + 8'(i), 8'hEE);
    @(negedge clk);
    src = 8'h10; dst = 8'h70; len = 9'd4; start = 1'b1;
    repeat (7) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("mrst_pre_rd", {31'd0, ram_re}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mrst_rd",   {31'd0, ram_re}, 32'd0);
    chk("mrst_wr",   {31'd0, ram_we}, 32'd0);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    saw_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) saw_done = 1;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done || busy) saw_done = 1;
    end
    chk("mrst_nodone", saw_done, 32'd0);
    chk("mrst_m0", {24'd0, mem[8'h70]}, 32'hA0);
    chk("mrst_m1", {24'd0, mem[8'h71]}, 32'hA1);
    chk("mrst_m2", {24'd0, mem[8'h72]}, 32'hEE);
    chk("mrst_m3", {24'd0, mem[8'h73]}, 32'hEE);

`ifdef RAM_COPY_FILL_EN
    poke(8'h35, 8'hEE);
    fill_mode = 1'b1; fill_value = 8'h5A;
    run(8'h99, 8'h30, 9'd5, 0, lat, bc, rc, wc, bth);
    fill_mode = 1'b0;
    chk("fill_lat", lat, 32'd6);
    chk("fill_rd",  rc, 32'd0);
    chk("fill_wr",  wc, 32'd5);
    for (int i = 0; i < 5; i++)
      chk("fill_mem", {24'd0, mem[8'h30 + 8'(i)]}, 32'h5A);
    chk("fill_m5", {24'd0, mem[8'h35]}, 32'hEE);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
